// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and transmitter state type (UART_SEND_PARITY_EN adds PARITY)
package uart_pkg;

  // Shared with the receive path so both ends agree on the baud rate.
  localparam int UART_CLKS_PER_BIT_DEF = 5200;
  localparam int UART_WIDTH_DEF        = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_SEND_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter with one-cycle bit_done pulse at the last count
module uart_baud_cnt import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic bit_done_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count 0..CLKS_PER_BIT-1 while enabled, wrapping on each bit boundary so bits never drift.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bit_done_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_send.sv
// rtl/uart_send.sv - UART transmitter, 8N1 by default; UART_SEND_PARITY_EN adds an even parity bit
module uart_send import uart_pkg::*; #(
  parameter int WIDTH        = UART_WIDTH_DEF,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
  parameter int STOP_BITS    = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_busy,
  output logic             uart_txd
);

  // The bit index also counts stop bits, so it must hold at least STOP_BITS-1.
  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  uart_tx_state_t   state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_nx;
  logic [IDX_W-1:0] idx_q;
  logic             txd_q;
  logic             ready_q;
  logic             busy_q;
`ifdef UART_SEND_PARITY_EN
  logic             parity_q;
`endif

  logic accept;
  logic bit_done;

  assign accept   = (state_q == IDLE) && tx_valid && ready_q;
  assign shift_nx = shift_q >> 1;

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .clr_i      (accept),
    .en_i       (state_q != IDLE),
    .bit_done_o (bit_done)
  );

  // Frame FSM; outputs are registered alongside the next state so the line is glitch-free.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      txd_q    <= 1'b1;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef UART_SEND_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          txd_q   <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          if (accept) begin
            shift_q  <= tx_data;
            idx_q    <= '0;
            state_q  <= START;
            txd_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
`ifdef UART_SEND_PARITY_EN
            parity_q <= ^tx_data;
`endif
          end
        end
        START: begin
          if (bit_done) begin
            state_q <= DATA;
            txd_q   <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            shift_q <= shift_nx;
            if (idx_q == IDX_LAST) begin
              idx_q <= '0;
`ifdef UART_SEND_PARITY_EN
              state_q <= PARITY;
              txd_q   <= parity_q;
`else
              state_q <= STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              idx_q <= idx_q + 1'b1;
              txd_q <= shift_nx[0];
            end
          end
        end
`ifdef UART_SEND_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            state_q <= STOP;
            txd_q   <= 1'b1;
          end
        end
`endif
        STOP: begin
          txd_q <= 1'b1;
          if (bit_done) begin
            if (idx_q == STOP_LAST) begin
              idx_q   <= '0;
              state_q <= IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign uart_txd = txd_q;

endmodule

// File: tb/tb_uart_send.sv
// tb/tb_uart_send.sv - directed table-driven bench for uart_send (UART_SEND_PARITY_EN aware)
module tb_uart_send;

  localparam int CPB = 16;
`ifdef UART_SEND_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       sys_clk;
  logic       sys_rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       uart_txd;

  int checks;
  int errors;
  int cyc;

  uart_send #(
    .WIDTH        (8),
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (1)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy),
    .uart_txd (uart_txd)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // seq holds the line bits in send order from bit 0: start, data LSB first, stop.
  typedef struct {
    logic [7:0] data;
    logic [9:0] seq;
    logic       par;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Send one frame and check every cycle of it; called at #1 after an edge with tx_ready high.
  task automatic run_frame(input vec_t v, input logic [7:0] data_after, input bit keep_valid,
                           input string name, output int t_acc);
    logic [10:0] exp;
    int          bad;
    int          stat_bad;
    logic        bad_val;
`ifdef UART_SEND_PARITY_EN
    exp = {1'b1, v.par, v.seq[8:0]};
`else
    exp = {1'b1, v.seq};
`endif
    check({name, "_ready_before"}, tx_ready, 1'b1);
    tx_data  = v.data;
    tx_valid = 1'b1;
    tick();
    t_acc    = cyc;
    tx_valid = keep_valid;
    tx_data  = data_after;
    for (int b = 0; b < NB; b++) begin
      bad      = 0;
      stat_bad = 0;
      bad_val  = exp[b];
      for (int c = 0; c < CPB; c++) begin
        if (uart_txd !== exp[b]) begin
          bad++;
          bad_val = uart_txd;
        end
        if (tx_ready !== 1'b0 || tx_busy !== 1'b1) stat_bad++;
        tick();
      end
      checks++;
      if (bad != 0 || stat_bad != 0) begin
        errors++;
        $display("FAIL %s_bit%0d actual txd %0b (%0d bad cycles, %0d bad status) required %0b",
                 name, b, bad_val, bad, stat_bad, exp[b]);
      end
    end
    check({name, "_end_ready"}, tx_ready, 1'b1);
    check({name, "_end_busy"}, tx_busy, 1'b0);
    check({name, "_end_txd"}, uart_txd, 1'b1);
  endtask

  int t0;
  int t1;

  initial begin
    checks = 0;
    errors = 0;

    vecs[0] = '{data: 8'h55, seq: 10'b1_01010101_0, par: 1'b0};
    vecs[1] = '{data: 8'hA3, seq: 10'b1_10100011_0, par: 1'b0};
    vecs[2] = '{data: 8'h0F, seq: 10'b1_00001111_0, par: 1'b0};
    vecs[3] = '{data: 8'h3C, seq: 10'b1_00111100_0, par: 1'b0};
    vecs[4] = '{data: 8'h00, seq: 10'b1_00000000_0, par: 1'b0};
    vecs[5] = '{data: 8'h81, seq: 10'b1_10000001_0, par: 1'b0};
    vecs[6] = '{data: 8'h07, seq: 10'b1_00000111_0, par: 1'b1};
    vecs[7] = '{data: 8'h03, seq: 10'b1_00000011_0, par: 1'b0};

    // Reset held for 5 cycles with tx_valid high.
    sys_rst  = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_txd", uart_txd, 1'b1);
      check("rst_ready", tx_ready, 1'b0);
    end
    check("rst_busy", tx_busy, 1'b0);
    sys_rst  = 1'b0;
    tx_valid = 1'b0;
    tick();
    check("rst_release_ready", tx_ready, 1'b1);
    check("rst_release_txd", uart_txd, 1'b1);

    // Table-driven single frames.
    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i], vecs[i].data, 1'b0, $sformatf("frame%0d", i), t0);
      tick();
    end

    // Back-to-back 0xA3 then 0x0F with tx_valid held.
    run_frame(vecs[1], vecs[2].data, 1'b1, "b2b_first", t0);
    run_frame(vecs[2], vecs[2].data, 1'b0, "b2b_second", t1);
    check("b2b_period", t1 - t0, CPB * NB + 1);
    tick();

    // Data stability: tx_data changes to 0xFF right after accept.
    run_frame(vecs[3], 8'hFF, 1'b0, "stable_3c", t0);
    tick();

    // Mid-frame reset during data bit 3 of 0x00.
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (70) tick();
    check("midrst_bit3_low", uart_txd, 1'b0);
    sys_rst = 1'b1;
    tick();
    check("midrst_txd", uart_txd, 1'b1);
    check("midrst_ready", tx_ready, 1'b0);
    check("midrst_busy", tx_busy, 1'b0);
    sys_rst = 1'b0;
    tick();
    check("midrst_release_ready", tx_ready, 1'b1);
    run_frame(vecs[5], vecs[5].data, 1'b0, "after_midrst", t0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
